sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Sequencer and two-port arbiter for the board's external 1M×32 asynchronous SRAM. It sits between the CPU's instruction-fetch port and data-memory port and the SRAM pins, granting one requester at a time. It generates the multi-cycle ce_n/oe_n/we_n sequences and handles byte-lane writes and sign/zero-extended byte reads. It is the only driver of the SRAM pins in the design.

## Interface
- RD_WAIT, 1: cycles ce_n/oe_n held low per read (≥1)
- WR_PULSE, 1: cycles ce_n/we_n held low per write (≥1)
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- if_req_valid / if_req_ready  in/out  1  fetch request handshake (read-only, word)
- if_addr  in  22  fetch byte address; [1:0] ignored
- if_rsp_valid  out  1  one-cycle pulse, fetch data valid
- if_rsp_data  out  32  fetch read word
- d_req_valid / d_req_ready  in/out  1  data request handshake
- d_addr  in  22  data byte address; word = [21:2], lane = [1:0]
- d_we  in  1  1 = write, 0 = read
- d_byte  in  1  1 = byte access, 0 = word (lane ignored)
- d_unsigned  in  1  byte read: 1 = zero-extend, 0 = sign-extend
- d_wdata  in  32  write data; byte writes use [7:0]
- d_rsp_valid  out  1  one-cycle pulse: read data valid / write complete
- d_rsp_data  out  32  read result; 0 for writes
- sram_ce_n, sram_oe_n, sram_we_n  out  1  SRAM strobes
- sram_be_n  out  4  SRAM byte enables, active-low
- sram_addr  out  20  SRAM word address
- sram_data  inout  32  SRAM data bus

## Operation
- States: IDLE, RD_ACCESS, WR_SETUP, WR_PULSE, WR_HOLD.
- IDLE: choose a requester. Default is fixed priority, data port over fetch. The selected port's ready is high only in IDLE with rst_n high. On valid&&ready, latch addr, op, lane and data, then go to RD_ACCESS (read) or WR_SETUP (write).
- RD_ACCESS: sram_ce_n = sram_oe_n = 0, be_n = 4'b0000, bus hi-Z. Stays RD_WAIT cycles. At the end of the last cycle, sram_data is registered into the granted port's rsp_data and rsp_valid pulses the next cycle. The state returns to IDLE at that same edge.
- Byte read: extract lane [8L+7:8L], extend from bit 8L+7 (or zero-extend if d_unsigned).
- WR_SETUP (1 cycle): addr, be_n and data are driven with strobes high.
- Word write: be_n = 0000, data = d_wdata.
- Byte write: be_n has 0 only at the lane; data = d_wdata[7:0] placed at the lane, other lanes 0.
- WR_PULSE: sram_ce_n = sram_we_n = 0 for WR_PULSE cycles.
- WR_HOLD (1 cycle): strobes high, addr, be_n and data still driven. d_rsp_valid pulses this cycle. Next state is IDLE.
- Bus drive: sram_data is driven only in WR_SETUP, WR_PULSE and WR_HOLD; it is hi-Z in all other states. we_n and oe_n are never low together.
- Requests must hold stable while valid && !ready.

## Timing
- Reset values: ce_n = oe_n = we_n = 1, be_n = 0000, sram_addr = 0, sram_data hi-Z, both ready = 0, both rsp_valid = 0, both rsp_data = 0. The state machine resets to IDLE.
- Read accepted at cycle T: strobes low T+1..T+RD_WAIT. rsp_valid at T+RD_WAIT+1. A new request may be accepted in that same cycle.
- Write accepted at T: setup T+1, pulse T+2..T+1+WR_PULSE, hold/ack T+2+WR_PULSE. IDLE follows.
- Both valid in IDLE: only one is granted; the loser's ready stays 0.
- rst_n asserted mid-transaction: all outputs take reset values immediately. The transaction is dropped and no response is issued.

## Configuration
- SRAM_ARB_ROUND_ROBIN_EN defined: round-robin arbitration via a last-grant flag.
  - When both ports are valid, grant the port not granted last.
  - Single-valid requests are always granted.
  - The flag resets to "fetch last", so data wins the first tie.
- SRAM_ARB_ROUND_ROBIN_EN undefined: fixed data-over-fetch priority; the flag is absent.

## Structure
- Package sram_arb_pkg holds:
  - state enum;
  - port-id enum (PORT_IF, PORT_D);
  - function be_n_for_lane(lane, byte);
  - function extract_byte(word, lane, unsigned).
- Sub-module sram_lane_unit: combinational be_n generation, write-data lane placement and read extraction. It is instantiated once.

## Test plan
- Word write 0xDEADBEEF to 0x00010, then fetch read of 0x00010 → if_rsp_data = 0xDEADBEEF at T+RD_WAIT+1; we_n low for exactly WR_PULSE cycles.
- Byte write 0x80 to d_addr 0x42, then signed byte read of 0x42 → be_n = 1011 during the write; read returns 0xFFFFFF80; unsigned read returns 0x00000080.
- Lane-2 signed read of word 0x00800000 → 0xFFFFFF80, which confirms extension uses bit 23.
- Both ports valid for 4 consecutive grants: without the macro, grants are D,D,D,D. With SRAM_ARB_ROUND_ROBIN_EN, grants are D,IF,D,IF.
- rst_n pulled low during WR_PULSE → ce_n = we_n = 1 and bus hi-Z in the same cycle; no d_rsp_valid is seen after release.
- Back-to-back reads → the second request is accepted in the first response's cycle, and oe_n is never low while sram_data is driven.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the external SRAM sequencer/arbiter.
// Used by sram_lane_unit and sram_arbiter.
package sram_arb_pkg;

  // Sequencer states: one read phase, three write phases.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ACCESS,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD
  } state_e;

  // Requester identity, used for response routing and the last-grant flag.
  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_e;

  // Active-low byte enables: all lanes for a word, a single lane for a byte.
  function automatic logic [3:0] be_n_for_lane(input logic [1:0] lane,
                                               input logic       is_byte);
    logic [3:0] be_n;
    be_n = 4'b0000;
    if (is_byte) begin
      be_n       = 4'b1111;
      be_n[lane] = 1'b0;
    end
    return be_n;
  endfunction

  // Pull one byte lane out of a word and sign- or zero-extend it to 32 bits.
  function automatic logic [31:0] extract_byte(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic        is_unsigned);
    logic [7:0] b;
    b = word[8*lane +: 8];
    return is_unsigned ? {24'h000000, b} : {{24{b[7]}}, b};
  endfunction

endpackage

// File: rtl/sram_lane_unit.sv
// Byte-lane steering for the SRAM data path: byte-enable generation,
// write-data lane placement and read-data extraction. Purely combinational.
module sram_lane_unit
  import sram_arb_pkg::*;
(
  input  logic [1:0]  i_lane,
  input  logic        i_byte,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be_n,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  // Word accesses pass straight through; byte accesses are steered to/from the lane.
  always_comb begin
    // NOTE: every output gets a default before any branch so no path leaves it
    // unassigned; that is what keeps this block free of inferred latches.
    o_be_n  = be_n_for_lane(i_lane, i_byte);
    o_wdata = i_wdata;
    o_rdata = i_rdata;
    if (i_byte) begin
      o_wdata              = 32'h0000_0000;
      o_wdata[8*i_lane +: 8] = i_wdata[7:0];
      o_rdata              = extract_byte(i_rdata, i_lane, i_unsigned);
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter and strobe sequencer for the external 1Mx32 async SRAM.
// Grants the fetch port or the data port one transaction at a time and
// generates the ce_n/oe_n/we_n sequences. Sole driver of the SRAM pins.
// Optional build macro: SRAM_ARB_ROUND_ROBIN_EN selects round-robin
// arbitration on ties; without it the data port always wins a tie.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int RD_WAIT  = 1,
  parameter int WR_PULSE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [21:0] if_addr,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_data,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic [21:0] d_addr,
  input  logic        d_we,
  input  logic        d_byte,
  input  logic        d_unsigned,
  input  logic [31:0] d_wdata,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_data,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic [3:0]  sram_be_n,
  output logic [19:0] sram_addr,
  inout  wire  [31:0] sram_data
);

  localparam int CNT_MAX = (RD_WAIT > WR_PULSE) ? RD_WAIT : WR_PULSE;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_PULSE - 1);

  state_e            r_state;
  state_e            w_next;
  logic [CNT_W-1:0]  r_cnt;
  port_e             r_port;
  logic              r_byte;
  logic              r_unsigned;
  logic [1:0]        r_lane;
  logic [19:0]       r_addr;
  logic [31:0]       r_wdata;
  logic              r_if_rsp_valid;
  logic              r_d_rsp_valid;
  logic [31:0]       r_if_rsp_data;
  logic [31:0]       r_d_rsp_data;

  logic              w_idle;
  logic              w_d_wins_tie;
  logic              w_grant_d;
  logic              w_accept;
  logic              w_rd_last;
  logic              w_wr_last;
  logic              w_drive;
  logic [3:0]        w_be_n;
  logic [31:0]       w_bus_wdata;
  logic [31:0]       w_rdata_ext;
  logic              w_if_addr_unused;

  // Fetches are word-only, so the byte offset of the fetch address is dropped.
  assign w_if_addr_unused = ^if_addr[1:0];

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  port_e r_last_grant;

  // Remember which port won the last grant so a tie goes to the other one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= PORT_IF;
    end else if (w_accept) begin
      r_last_grant <= w_grant_d ? PORT_D : PORT_IF;
    end
  end

  assign w_d_wins_tie = (r_last_grant == PORT_IF);
`else
  assign w_d_wins_tie = 1'b1;
`endif

  // Arbitration: a lone requester is always selected; a tie uses the tie rule.
  assign w_grant_d    = d_req_valid && (!if_req_valid || w_d_wins_tie);
  assign w_idle       = (r_state == ST_IDLE);
  assign d_req_ready  = rst_n && w_idle && w_grant_d;
  assign if_req_ready = rst_n && w_idle && !w_grant_d;
  assign w_accept     = (d_req_valid && d_req_ready) || (if_req_valid && if_req_ready);

  assign w_rd_last = (r_cnt == RD_LAST);
  assign w_wr_last = (r_cnt == WR_LAST);

  sram_lane_unit u_lane (
    .i_lane     (r_lane),
    .i_byte     (r_byte),
    .i_unsigned (r_unsigned),
    .i_wdata    (r_wdata),
    .i_rdata    (sram_data),
    .o_be_n     (w_be_n),
    .o_wdata    (w_bus_wdata),
    .o_rdata    (w_rdata_ext)
  );

  // State register plus a per-state cycle counter that restarts on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, regardless of statement order.
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next == r_state && r_state != ST_IDLE) ? r_cnt + 1'b1 : '0;
    end
  end

  // Next-state decode and SRAM strobe/bus-enable generation for the current state.
  always_comb begin
    w_next    = r_state;
    sram_ce_n = 1'b1;
    sram_oe_n = 1'b1;
    sram_we_n = 1'b1;
    sram_be_n = 4'b0000;
    w_drive   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next = (w_grant_d && d_we) ? ST_WR_SETUP : ST_RD_ACCESS;
      end
      ST_RD_ACCESS: begin
        sram_ce_n = 1'b0;
        sram_oe_n = 1'b0;
        if (w_rd_last) w_next = ST_IDLE;
      end
      ST_WR_SETUP: begin
        sram_be_n = w_be_n;
        w_drive   = 1'b1;
        w_next    = ST_WR_PULSE;
      end
      ST_WR_PULSE: begin
        sram_ce_n = 1'b0;
        sram_we_n = 1'b0;
        sram_be_n = w_be_n;
        w_drive   = 1'b1;
        if (w_wr_last) w_next = ST_WR_HOLD;
      end
      ST_WR_HOLD: begin
        sram_be_n = w_be_n;
        w_drive   = 1'b1;
        w_next    = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Capture the granted request so the SRAM sees stable address/data for the whole access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_port     <= PORT_IF;
      r_byte     <= 1'b0;
      r_unsigned <= 1'b0;
      r_lane     <= 2'b00;
      r_addr     <= 20'h00000;
      r_wdata    <= 32'h0000_0000;
    end else if (w_accept) begin
      if (w_grant_d) begin
        r_port     <= PORT_D;
        r_byte     <= d_byte;
        r_unsigned <= d_unsigned;
        r_lane     <= d_addr[1:0];
        r_addr     <= d_addr[21:2];
        r_wdata    <= d_wdata;
      end else begin
        r_port     <= PORT_IF;
        r_byte     <= 1'b0;
        r_unsigned <= 1'b0;
        r_lane     <= 2'b00;
        r_addr     <= if_addr[21:2];
      end
    end
  end

  // Response pulses: read data registered at the end of the access, write ack on entry to hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_rsp_valid <= 1'b0;
      r_d_rsp_valid  <= 1'b0;
      r_if_rsp_data  <= 32'h0000_0000;
      r_d_rsp_data   <= 32'h0000_0000;
    end else begin
      r_if_rsp_valid <= 1'b0;
      r_d_rsp_valid  <= 1'b0;
      if (r_state == ST_RD_ACCESS && w_rd_last) begin
        if (r_port == PORT_D) begin
          r_d_rsp_valid <= 1'b1;
          r_d_rsp_data  <= w_rdata_ext;
        end else begin
          r_if_rsp_valid <= 1'b1;
          r_if_rsp_data  <= w_rdata_ext;
        end
      end
      if (r_state == ST_WR_PULSE && w_wr_last) begin
        r_d_rsp_valid <= 1'b1;
        r_d_rsp_data  <= 32'h0000_0000;
      end
    end
  end

  assign if_rsp_valid = r_if_rsp_valid;
  assign if_rsp_data  = r_if_rsp_data;
  assign d_rsp_valid  = r_d_rsp_valid;
  assign d_rsp_data   = r_d_rsp_data;
  assign sram_addr    = r_addr;
  assign sram_data    = w_drive ? w_bus_wdata : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: SRAM model on the pins, a
// transaction-level reference model checked every cycle, and directed
// vectors with literal expectations.
`timescale 1ns/1ps
module tb_sram_arbiter;

  localparam int RD_WAIT  = 3;
  localparam int WR_PULSE = 2;
  localparam logic [31:0] KEEP = 32'h5A5A_C3C3;

  logic        clk;
  logic        rst_n;
  logic        if_req_valid, if_req_ready;
  logic [21:0] if_addr;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        d_req_valid, d_req_ready;
  logic [21:0] d_addr;
  logic        d_we, d_byte, d_unsigned;
  logic [31:0] d_wdata;
  logic        d_rsp_valid;
  logic [31:0] d_rsp_data;
  logic        sram_ce_n, sram_oe_n, sram_we_n;
  logic [3:0]  sram_be_n;
  logic [19:0] sram_addr;
  wire  [31:0] sram_data;

  sram_arbiter #(.RD_WAIT(RD_WAIT), .WR_PULSE(WR_PULSE)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
    .d_we(d_we), .d_byte(d_byte), .d_unsigned(d_unsigned), .d_wdata(d_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_be_n(sram_be_n), .sram_addr(sram_addr), .sram_data(sram_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- SRAM pin model ----------------
  logic [31:0] mem [0:255];
  bit          mem_init_done = 1'b0;
  logic        probe_en = 1'b0;
  logic        tb_drv;
  logic [31:0] tb_val;

  // The SRAM drives on reads; the bench also drives a keeper pattern during
  // reset or an idle probe, so any concurrent DUT drive corrupts the value.
  assign tb_drv = (!sram_ce_n && !sram_oe_n) || !rst_n || probe_en;
  assign tb_val = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[7:0]] : KEEP;
  assign sram_data = tb_drv ? tb_val : 32'hzzzz_zzzz;

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem_init_done <= 1'b1;
    end else if (rst_n && !sram_ce_n && !sram_we_n) begin
      for (int b = 0; b < 4; b++)
        if (!sram_be_n[b]) mem[sram_addr[7:0]][8*b +: 8] <= sram_data[8*b +: 8];
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [0:255];
  bit          m_act = 0;
  int          m_t0;
  bit          m_port;      // 1 = data port
  bit          m_wr;
  logic [19:0] m_addr;
  logic [3:0]  m_be;
  logic [31:0] m_wbus;
  logic [31:0] m_rsp;
  bit          m_last_d = 0;
  int          grant_q[$];
  int          last_acc_cyc, last_d_cyc;
  int          d_rsp_cnt = 0;
  int          we_low_cnt = 0;
  logic [3:0]  we_be;
  logic [31:0] e_ce, e_oe, e_we, e_drsp, e_ifrsp;
  bit          idle, pref_d, e_dr;
  int          k;

  task automatic start_d();
    logic [1:0]  lane;
    logic [31:0] w, bv;
    m_act = 1; m_t0 = cyc; m_port = 1; m_wr = d_we;
    m_addr = d_addr[21:2]; lane = d_addr[1:0];
    if (d_we) begin
      if (d_byte) begin
        m_be   = 4'b1111 & ~(4'b0001 << lane);
        m_wbus = {24'h0, d_wdata[7:0]} << (8 * lane);
      end else begin
        m_be   = 4'b0000;
        m_wbus = d_wdata;
      end
      m_rsp = 32'h0;
      for (int b = 0; b < 4; b++)
        if (!m_be[b]) ref_mem[m_addr[7:0]][8*b +: 8] = m_wbus[8*b +: 8];
    end else begin
      m_be = 4'b0000;
      w = ref_mem[m_addr[7:0]];
      if (d_byte) begin
        bv = (w >> (8 * lane)) & 32'hFF;
        if (d_unsigned || bv < 128) m_rsp = bv;
        else                        m_rsp = bv | 32'hFFFF_FF00;
      end else begin
        m_rsp = w;
      end
    end
  endtask

  // Compare every output against the model on the falling edge of each cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst ce_n", sram_ce_n, 1); check("rst oe_n", sram_oe_n, 1);
      check("rst we_n", sram_we_n, 1); check("rst be_n", sram_be_n, 0);
      check("rst addr", sram_addr, 0); check("rst if_ready", if_req_ready, 0);
      check("rst d_ready", d_req_ready, 0); check("rst if_rsp_valid", if_rsp_valid, 0);
      check("rst d_rsp_valid", d_rsp_valid, 0); check("rst if_rsp_data", if_rsp_data, 0);
      check("rst d_rsp_data", d_rsp_data, 0);
      m_act = 0; m_last_d = 0;
    end else begin
      e_ce = 1; e_oe = 1; e_we = 1; e_drsp = 0; e_ifrsp = 0; idle = 1;
      if (!sram_we_n) begin we_low_cnt++; we_be = sram_be_n; end
      if (m_act) begin
        k = cyc - m_t0;
        if (!m_wr) begin
          if (k <= RD_WAIT) begin
            idle = 0; e_ce = 0; e_oe = 0;
            check("rd addr", sram_addr, m_addr);
            check("rd be_n", sram_be_n, 0);
            check("rd bus", sram_data, ref_mem[m_addr[7:0]]);
          end else begin
            if (m_port) e_drsp = 1; else e_ifrsp = 1;
            m_act = 0;
          end
        end else begin
          idle = 0;
          if (k >= 2 && k <= 1 + WR_PULSE) begin e_ce = 0; e_we = 0; end
          if (k == 2 + WR_PULSE) begin e_drsp = 1; m_act = 0; end
          check("wr addr", sram_addr, m_addr);
          check("wr be_n", sram_be_n, m_be);
          check("wr bus", sram_data, m_wbus);
        end
      end
      check("ce_n", sram_ce_n, e_ce); check("oe_n", sram_oe_n, e_oe);
      check("we_n", sram_we_n, e_we);
      check("d_rsp_valid", d_rsp_valid, e_drsp);
      check("if_rsp_valid", if_rsp_valid, e_ifrsp);
      if (e_drsp == 1)  check("d_rsp_data", d_rsp_data, m_rsp);
      if (e_ifrsp == 1) check("if_rsp_data", if_rsp_data, m_rsp);
      if (d_rsp_valid) begin d_rsp_cnt++; last_d_cyc = cyc; end
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      pref_d = !m_last_d;
`else
      pref_d = 1;
`endif
      if (!idle) begin
        check("busy d_ready", d_req_ready, 0);
        check("busy if_ready", if_req_ready, 0);
      end else if (d_req_valid || if_req_valid) begin
        e_dr = d_req_valid && (!if_req_valid || pref_d);
        check("d_ready", d_req_ready, e_dr);
        check("if_ready", if_req_ready, !e_dr);
        last_acc_cyc = cyc;
        if (e_dr) begin
          start_d(); m_last_d = 1; grant_q.push_back(1);
        end else begin
          m_act = 1; m_t0 = cyc; m_port = 0; m_wr = 0;
          m_addr = if_addr[21:2]; m_be = 4'b0000;
          m_rsp = ref_mem[m_addr[7:0]];
          m_last_d = 0; grant_q.push_back(0);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic d_issue(input logic we, input logic byt, input logic uns,
                         input logic [21:0] a, input logic [31:0] wd);
    bit ok;
    ok = 0;
    d_we = we; d_byte = byt; d_unsigned = uns; d_addr = a; d_wdata = wd;
    d_req_valid = 1;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk); ok = d_req_ready;
      @(posedge clk); #1;
    end
    d_req_valid = 0;
    check("d accept within budget", ok, 1);
  endtask

  task automatic if_issue(input logic [21:0] a);
    bit ok;
    ok = 0;
    if_addr = a; if_req_valid = 1;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk); ok = if_req_ready;
      @(posedge clk); #1;
    end
    if_req_valid = 0;
    check("if accept within budget", ok, 1);
  endtask

  task automatic wait_d_rsp(output logic [31:0] data);
    bit got;
    got = 0; data = 32'hxxxx_xxxx;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if (d_rsp_valid) begin got = 1; data = d_rsp_data; end
    end
    @(posedge clk); #1;
    check("d rsp within budget", got, 1);
  endtask

  task automatic wait_if_rsp(output logic [31:0] data, output int c);
    bit got;
    got = 0; data = 32'hxxxx_xxxx; c = -1;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if (if_rsp_valid) begin got = 1; data = if_rsp_data; c = cyc; end
    end
    @(posedge clk); #1;
    check("if rsp within budget", got, 1);
  endtask

  // ---------------- directed sequence ----------------
  logic [31:0] r;
  int          rc, acc, cnt_before;
  logic [21:0] lane_addr [4] = '{22'h10, 22'h11, 22'h12, 22'h13};
  logic        lane_uns  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic [31:0] lane_exp  [4] = '{32'hFFFF_FFEF, 32'h0000_00BE, 32'hFFFF_FFAD, 32'hFFFF_FFDE};
  int          exp_grants [4];

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
    rst_n = 0; if_req_valid = 0; if_addr = 0; d_req_valid = 0; d_addr = 0;
    d_we = 0; d_byte = 0; d_unsigned = 0; d_wdata = 0;
    #1;
    check("init ce_n", sram_ce_n, 1); check("init we_n", sram_we_n, 1);
    check("init oe_n", sram_oe_n, 1); check("init bus released", sram_data, KEEP);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;

    // Word write then fetch of the same word.
    we_low_cnt = 0;
    d_issue(1, 0, 0, 22'h10, 32'hDEAD_BEEF);
    wait_d_rsp(r);
    check("word write ack data", r, 32'h0);
    check("we_n low cycles", we_low_cnt, WR_PULSE);
    if_issue(22'h10);
    acc = last_acc_cyc;
    wait_if_rsp(r, rc);
    check("fetch data", r, 32'hDEAD_BEEF);
    check("fetch latency", rc - acc, RD_WAIT + 1);

    // Byte reads of every lane of 0xDEADBEEF.
    for (int i = 0; i < 4; i++) begin
      d_issue(0, 1, lane_uns[i], lane_addr[i], 32'h0);
      wait_d_rsp(r);
      check("lane read", r, lane_exp[i]);
    end

    // Byte write 0x80 at 0x42, signed and unsigned read-back.
    we_low_cnt = 0;
    d_issue(1, 1, 0, 22'h42, 32'hAAAA_AA80);
    wait_d_rsp(r);
    check("byte write be_n", we_be, 4'b1011);
    d_issue(0, 1, 0, 22'h42, 32'h0);
    wait_d_rsp(r);
    check("signed byte read", r, 32'hFFFF_FF80);
    d_issue(0, 1, 1, 22'h42, 32'h0);
    wait_d_rsp(r);
    check("unsigned byte read", r, 32'h0000_0080);
    d_issue(0, 0, 0, 22'h40, 32'h0);
    wait_d_rsp(r);
    check("word after byte write", r, 32'h0080_0000);

    // Lane-2 sign extension from bit 23.
    d_issue(1, 0, 0, 22'h80, 32'h0080_0000);
    wait_d_rsp(r);
    d_issue(0, 1, 0, 22'h82, 32'h0);
    wait_d_rsp(r);
    check("lane2 sign from bit23", r, 32'hFFFF_FF80);

    // Both ports valid continuously for four grants.
    grant_q.delete();
    d_we = 0; d_byte = 0; d_unsigned = 0; d_addr = 22'h10;
    if_addr = 22'h83;
    d_req_valid = 1; if_req_valid = 1;
    for (int i = 0; i < 200 && grant_q.size() < 4; i++) begin
      @(posedge clk); #1;
    end
    d_req_valid = 0; if_req_valid = 0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    exp_grants = '{1, 0, 1, 0};
`else
    exp_grants = '{1, 1, 1, 1};
`endif
    check("grant count", grant_q.size(), 4);
    for (int i = 0; i < 4 && i < grant_q.size(); i++)
      check("grant order", grant_q[i], exp_grants[i]);
    repeat (10) @(posedge clk);
    #1;

    // Back-to-back: fetch accepted in the data read's response cycle.
    d_issue(0, 0, 0, 22'h10, 32'h0);
    if_issue(22'h80);
    check("b2b accept in rsp cycle", last_acc_cyc, last_d_cyc);
    wait_if_rsp(r, rc);
    check("b2b fetch data", r, 32'h0080_0000);

    // Idle bus must be released.
    repeat (2) @(posedge clk);
    #1 probe_en = 1;
    @(negedge clk);
    check("idle bus released", sram_data, KEEP);
    @(posedge clk); #1 probe_en = 0;

    // Reset during the write pulse.
    d_issue(1, 0, 0, 22'hF0, 32'h1234_5678);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (!sram_we_n) break;
    end
    check("reached write pulse", sram_we_n, 0);
    #2 rst_n = 0;
    #1;
    check("async rst ce_n", sram_ce_n, 1);
    check("async rst we_n", sram_we_n, 1);
    check("async rst bus released", sram_data, KEEP);
    check("async rst d_rsp_valid", d_rsp_valid, 0);
    @(posedge clk); #1;
    @(posedge clk); #1 rst_n = 1;
    cnt_before = d_rsp_cnt;
    repeat (10) @(posedge clk);
    #1;
    check("no rsp after dropped write", d_rsp_cnt, cnt_before);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
